// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT P/Q calculator: channel count, word widths,
// the sequencer state type and the channel index type.
package fft_pkg;

  localparam int NCH = 7;
  localparam int DW  = 32;
  localparam int PQW = 64;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    OUT
  } state_e;

  typedef logic [2:0] ch_idx_t;

endpackage

// File: rtl/fft_pq_calc_if.sv
// Frame bus between the voltage/current FFT engines, the P/Q calculator and its result consumer.
// slave = calculator side; master = the side that supplies frames and accepts results.
interface fft_pq_calc_if #(
  parameter int NCH = fft_pkg::NCH,
  parameter int DW  = fft_pkg::DW
) ();

  logic [NCH*DW-1:0]                u_re_bus;
  logic [NCH*DW-1:0]                u_im_bus;
  logic                             done1;
  logic [NCH*DW-1:0]                i_re_bus;
  logic [NCH*DW-1:0]                i_im_bus;
  logic                             done2;
  logic                             pq_valid;
  logic                             pq_ready;
  logic [2:0]                       pq_ch;
  logic signed [fft_pkg::PQW-1:0]   p_out;
  logic signed [fft_pkg::PQW-1:0]   q_out;
  logic                             frame_done;
  logic                             overrun;

  modport slave (
    input  u_re_bus, u_im_bus, done1, i_re_bus, i_im_bus, done2, pq_ready,
    output pq_valid, pq_ch, p_out, q_out, frame_done, overrun
  );

  modport master (
    output u_re_bus, u_im_bus, done1, i_re_bus, i_im_bus, done2, pq_ready,
    input  pq_valid, pq_ch, p_out, q_out, frame_done, overrun
  );

endinterface

// File: rtl/fft_pq_mac.sv
// Per-channel P/Q pipeline: MUL registers four signed products, ADD registers P and Q.
// FFT_PQ_SAT_EN selects saturating sums; otherwise sums wrap modulo 2^64.
module fft_pq_mac #(
  parameter int DW = fft_pkg::DW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mul_en,
  input  logic                           add_en,
  input  logic signed [DW-1:0]           ur,
  input  logic signed [DW-1:0]           ui,
  input  logic signed [DW-1:0]           ir,
  input  logic signed [DW-1:0]           ii,
  output logic signed [fft_pkg::PQW-1:0] p,
  output logic signed [fft_pkg::PQW-1:0] q
);

  localparam int PQW = fft_pkg::PQW;

  logic signed [PQW-1:0] ur_x, ui_x, ir_x, ii_x;
  logic signed [PQW-1:0] m_rr_q, m_rr_d, m_ii_q, m_ii_d;
  logic signed [PQW-1:0] m_ir_q, m_ir_d, m_ri_q, m_ri_d;
  logic signed [PQW-1:0] p_q, p_d, q_q, q_d;
  logic signed [PQW-1:0] p_fit, q_fit;

  assign ur_x = {{(PQW-DW){ur[DW-1]}}, ur};
  assign ui_x = {{(PQW-DW){ui[DW-1]}}, ui};
  assign ir_x = {{(PQW-DW){ir[DW-1]}}, ir};
  assign ii_x = {{(PQW-DW){ii[DW-1]}}, ii};

`ifdef FFT_PQ_SAT_EN
  // One guard bit catches the only overflow case, e.g. (-2^31)^2 + (-2^31)^2 = 2^63.
  logic signed [PQW:0] p_sum, q_sum;

  assign p_sum = {m_rr_q[PQW-1], m_rr_q} + {m_ii_q[PQW-1], m_ii_q};
  assign q_sum = {m_ir_q[PQW-1], m_ir_q} - {m_ri_q[PQW-1], m_ri_q};

  always_comb begin
    p_fit = p_sum[PQW-1:0];
    q_fit = q_sum[PQW-1:0];
    if (p_sum[PQW] != p_sum[PQW-1]) begin
      p_fit = p_sum[PQW] ? {1'b1, {(PQW-1){1'b0}}} : {1'b0, {(PQW-1){1'b1}}};
    end
    if (q_sum[PQW] != q_sum[PQW-1]) begin
      q_fit = q_sum[PQW] ? {1'b1, {(PQW-1){1'b0}}} : {1'b0, {(PQW-1){1'b1}}};
    end
  end
`else
  assign p_fit = m_rr_q + m_ii_q;
  assign q_fit = m_ir_q - m_ri_q;
`endif

  always_comb begin
    m_rr_d = m_rr_q;
    m_ii_d = m_ii_q;
    m_ir_d = m_ir_q;
    m_ri_d = m_ri_q;
    p_d    = p_q;
    q_d    = q_q;
    if (mul_en) begin
      m_rr_d = ur_x * ir_x;
      m_ii_d = ui_x * ii_x;
      m_ir_d = ui_x * ir_x;
      m_ri_d = ur_x * ii_x;
    end
    if (add_en) begin
      p_d = p_fit;
      q_d = q_fit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_rr_q <= '0;
      m_ii_q <= '0;
      m_ir_q <= '0;
      m_ri_q <= '0;
      p_q    <= '0;
      q_q    <= '0;
    end else begin
      m_rr_q <= m_rr_d;
      m_ii_q <= m_ii_d;
      m_ir_q <= m_ir_d;
      m_ri_q <= m_ri_d;
      p_q    <= p_d;
      q_q    <= q_d;
    end
  end

  assign p = p_q;
  assign q = q_q;

endmodule

// File: rtl/fft_pq_calc.sv
// Per-channel active/reactive power from captured U and I FFT frames; first result 3 cycles after
// the second done, then 2 cycles after each handshake; results hold until pq_ready (FFT_PQ_SAT_EN: saturate).
module fft_pq_calc #(
  parameter int NCH = fft_pkg::NCH,
  parameter int DW  = fft_pkg::DW
) (
  input logic          clk,
  input logic          fft_reset,
  fft_pq_calc_if.slave bus
);

  import fft_pkg::*;

  state_e             state_q, state_d;
  logic               u_flag_q, u_flag_d;
  logic               i_flag_q, i_flag_d;
  ch_idx_t            ch_q, ch_d;
  ch_idx_t            sel_idx;
  logic               mul_en, add_en;
  logic               last_ch;
  logic [NCH*DW-1:0]  u_re_q, u_re_d, u_im_q, u_im_d;
  logic [NCH*DW-1:0]  i_re_q, i_re_d, i_im_q, i_im_d;
  logic signed [PQW-1:0] p_res, q_res;

  // Frame buffers only load in IDLE; a done arriving mid-frame leaves them untouched.
  always_comb begin
    u_re_d = u_re_q;
    u_im_d = u_im_q;
    i_re_d = i_re_q;
    i_im_d = i_im_q;
    if (state_q == IDLE && bus.done1) begin
      u_re_d = bus.u_re_bus;
      u_im_d = bus.u_im_bus;
    end
    if (state_q == IDLE && bus.done2) begin
      i_re_d = bus.i_re_bus;
      i_im_d = bus.i_im_bus;
    end
  end

  always_ff @(posedge clk) begin
    u_re_q <= u_re_d;
    u_im_q <= u_im_d;
    i_re_q <= i_re_d;
    i_im_q <= i_im_d;
  end

  assign last_ch = (ch_q == ch_idx_t'(NCH));

  always_comb begin
    state_d  = state_q;
    u_flag_d = u_flag_q;
    i_flag_d = i_flag_q;
    ch_d     = ch_q;
    mul_en   = 1'b0;
    add_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.done1) u_flag_d = 1'b1;
        if (bus.done2) i_flag_d = 1'b1;
        if (u_flag_q && i_flag_q) begin
          state_d  = MUL;
          u_flag_d = 1'b0;
          i_flag_d = 1'b0;
          ch_d     = ch_idx_t'(1);
        end
      end
      MUL: begin
        mul_en  = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        add_en  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (bus.pq_ready) begin
          if (last_ch) begin
            state_d = IDLE;
          end else begin
            state_d = MUL;
            ch_d    = ch_q + ch_idx_t'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fft_reset) begin
      state_q  <= IDLE;
      u_flag_q <= 1'b0;
      i_flag_q <= 1'b0;
      ch_q     <= '0;
    end else begin
      state_q  <= state_d;
      u_flag_q <= u_flag_d;
      i_flag_q <= i_flag_d;
      ch_q     <= ch_d;
    end
  end

  // Channels are numbered from 1; ch_q is 0 only between reset and the first frame.
  assign sel_idx = (ch_q == '0) ? '0 : ch_q - ch_idx_t'(1);

  fft_pq_mac #(
    .DW(DW)
  ) u_mac (
    .clk    (clk),
    .rst    (fft_reset),
    .mul_en (mul_en),
    .add_en (add_en),
    .ur     (u_re_q[sel_idx*DW +: DW]),
    .ui     (u_im_q[sel_idx*DW +: DW]),
    .ir     (i_re_q[sel_idx*DW +: DW]),
    .ii     (i_im_q[sel_idx*DW +: DW]),
    .p      (p_res),
    .q      (q_res)
  );

  assign bus.pq_valid   = (state_q == OUT);
  assign bus.pq_ch      = ch_q;
  assign bus.p_out      = p_res;
  assign bus.q_out      = q_res;
  assign bus.frame_done = (state_q == OUT) && bus.pq_ready && last_ch;
  assign bus.overrun    = (state_q != IDLE) && (bus.done1 || bus.done2);

endmodule

// File: tb/tb_fft_pq_calc.sv
// Directed bench for fft_pq_calc: a reference model queues expected P/Q per channel when frames
// are issued; a monitor pops and compares on every result handshake.
module tb_fft_pq_calc;

  localparam int NCH = 7;
  localparam int DW  = 32;

  typedef struct {
    int          ch;
    logic [63:0] p;
    logic [63:0] q;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic fft_reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  logic signed [DW-1:0] u_re[1:NCH], u_im[1:NCH], i_re[1:NCH], i_im[1:NCH];
  logic signed [DW-1:0] cu_re[1:NCH], cu_im[1:NCH], ci_re[1:NCH], ci_im[1:NCH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_pq_calc_if #(.NCH(NCH), .DW(DW)) bus ();

  fft_pq_calc #(.NCH(NCH), .DW(DW)) dut (
    .clk       (clk),
    .fft_reset (fft_reset),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] mac_ref(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                                          input logic signed [DW-1:0] c, input logic signed [DW-1:0] d,
                                          input bit sub);
    logic signed [64:0] x1, x2, x3, x4, s;
    x1 = a; x2 = b; x3 = c; x4 = d;
    s = sub ? (x1 * x2) - (x3 * x4) : (x1 * x2) + (x3 * x4);
`ifdef FFT_PQ_SAT_EN
    if (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (s < -65'sh0_8000_0000_0000_0000) return 64'h8000_0000_0000_0000;
`endif
    return s[63:0];
  endfunction

  task automatic rand_u();
    for (int k = 1; k <= NCH; k++) begin
      u_re[k] = $urandom;
      u_im[k] = $urandom;
    end
  endtask

  task automatic rand_i();
    for (int k = 1; k <= NCH; k++) begin
      i_re[k] = $urandom;
      i_im[k] = $urandom;
    end
  endtask

  task automatic drive_buses();
    for (int k = 1; k <= NCH; k++) begin
      bus.u_re_bus[(k-1)*DW +: DW] = u_re[k];
      bus.u_im_bus[(k-1)*DW +: DW] = u_im[k];
      bus.i_re_bus[(k-1)*DW +: DW] = i_re[k];
      bus.i_im_bus[(k-1)*DW +: DW] = i_im[k];
    end
  endtask

  // Called #1 after a rising edge; the pulse is sampled by the next edge.
  task automatic pulse(input bit d1, input bit d2);
    drive_buses();
    bus.done1 = d1;
    bus.done2 = d2;
    @(posedge clk); #1;
    bus.done1 = 1'b0;
    bus.done2 = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      if (d1) begin cu_re[k] = u_re[k]; cu_im[k] = u_im[k]; end
      if (d2) begin ci_re[k] = i_re[k]; ci_im[k] = i_im[k]; end
    end
  endtask

  task automatic push_frame(input int first_cyc, input bit fix1, input logic [63:0] p1, input logic [63:0] q1);
    exp_t e;
    for (int k = 1; k <= NCH; k++) begin
      e.ch  = k;
      e.p   = mac_ref(cu_re[k], ci_re[k], cu_im[k], ci_im[k], 1'b0);
      e.q   = mac_ref(cu_im[k], ci_re[k], cu_re[k], ci_im[k], 1'b1);
      e.cyc = (first_cyc < 0) ? -1 : first_cyc + 3 * (k - 1);
      if (fix1 && k == 1) begin
        e.p = p1;
        e.q = q1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid(input int maxc);
    int n;
    n = 0;
    while (bus.pq_valid !== 1'b1 && n < maxc) begin @(posedge clk); #1; n++; end
    chk("wait_valid", 64'(bus.pq_valid), 64'd1);
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin @(posedge clk); #1; n++; end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(bus.pq_valid), 64'd0);
    chk({tag, "_ch"}, 64'(bus.pq_ch), 64'd0);
    chk({tag, "_p"}, bus.p_out, 64'd0);
    chk({tag, "_q"}, bus.q_out, 64'd0);
    chk({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
    chk({tag, "_overrun"}, 64'(bus.overrun), 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.pq_valid === 1'b1 && bus.pq_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_result: observed ch %0d with nothing pending, expected no result", bus.pq_ch);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pq_ch", 64'(bus.pq_ch), 64'(e.ch));
        chk("p_out", bus.p_out, e.p);
        chk("q_out", bus.q_out, e.q);
        chk("frame_done", 64'(bus.frame_done), 64'(e.ch == NCH));
        if (e.cyc >= 0) chk("result_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    fft_reset    = 1'b1;
    bus.done1    = 1'b0;
    bus.done2    = 1'b0;
    bus.pq_ready = 1'b0;
    bus.u_re_bus = '0;
    bus.u_im_bus = '0;
    bus.i_re_bus = '0;
    bus.i_im_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    fft_reset = 1'b0;

    // Frame timing: done1 sampled at edge 10, done2 at edge 15, ch1 (3,4)x(5,-2) -> P=7, Q=26.
    rand_u(); rand_i();
    u_re[1] = 3; u_im[1] = 4; i_re[1] = 5; i_im[1] = -2;
    bus.pq_ready = 1'b1;
    goto_cyc(9);
    pulse(1'b1, 1'b0);
    goto_cyc(14);
    pulse(1'b0, 1'b1);
    push_frame(18, 1'b1, 64'd7, 64'd26);
    wait_drain(60);

    // Simultaneous dones, consumer stalls for 10 cycles on ch1.
    bus.pq_ready = 1'b0;
    rand_u(); rand_i();
    pulse(1'b1, 1'b1);
    push_frame(-1, 1'b0, '0, '0);
    repeat (2) begin @(posedge clk); #1; chk("latency_low", 64'(bus.pq_valid), 64'd0); end
    @(posedge clk); #1;
    chk("latency_high", 64'(bus.pq_valid), 64'd1);
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", 64'(bus.pq_valid), 64'd1);
      chk("stall_ch", 64'(bus.pq_ch), 64'd1);
      chk("stall_p", bus.p_out, sb[0].p);
      chk("stall_q", bus.q_out, sb[0].q);
      @(posedge clk); #1;
    end
    bus.pq_ready = 1'b1;
    wait_drain(60);

    // done1 while a result is pending: overrun pulse, buffers and flags untouched.
    bus.pq_ready = 1'b0;
    rand_u(); rand_i();
    pulse(1'b1, 1'b1);
    push_frame(-1, 1'b0, '0, '0);
    wait_valid(10);
    rand_u();
    drive_buses();
    bus.done1 = 1'b1;
    #1;
    chk("overrun_pulse", 64'(bus.overrun), 64'd1);
    @(posedge clk); #1;
    bus.done1 = 1'b0;
    #1;
    chk("overrun_clear", 64'(bus.overrun), 64'd0);
    bus.pq_ready = 1'b1;
    wait_drain(60);
    rand_i();
    pulse(1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      chk("wait_both_dones", 64'(bus.pq_valid), 64'd0);
      @(posedge clk); #1;
    end
    pulse(1'b1, 1'b0);
    push_frame(-1, 1'b0, '0, '0);
    wait_drain(60);

    // Extreme operands: exact sum near the top of range, then a true overflow of P.
    rand_u(); rand_i();
    u_re[1] = 32'h8000_0000; u_im[1] = 32'h8000_0000;
    i_re[1] = 32'h8000_0000; i_im[1] = 32'h7FFF_FFFF;
    pulse(1'b1, 1'b1);
    push_frame(-1, 1'b1, 64'h0000_0000_8000_0000, 64'h7FFF_FFFF_8000_0000);
    wait_drain(60);
    i_im[1] = 32'h8000_0000;
    pulse(1'b1, 1'b1);
`ifdef FFT_PQ_SAT_EN
    push_frame(-1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
`else
    push_frame(-1, 1'b1, 64'h8000_0000_0000_0000, 64'd0);
`endif
    wait_drain(60);

    // Reset while ch4 is on offer abandons the frame.
    bus.pq_ready = 1'b0;
    rand_u(); rand_i();
    pulse(1'b1, 1'b1);
    push_frame(-1, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      wait_valid(10);
      bus.pq_ready = 1'b1;
      @(posedge clk); #1;
      bus.pq_ready = 1'b0;
    end
    wait_valid(10);
    chk("pre_reset_ch", 64'(bus.pq_ch), 64'd4);
    fft_reset = 1'b1;
    @(posedge clk); #1;
    fft_reset = 1'b0;
    sb.delete();
    chk_idle_outputs("midframe_reset");
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", 64'(bus.pq_valid), 64'd0);
    end
    bus.pq_ready = 1'b1;
    rand_u(); rand_i();
    pulse(1'b1, 1'b1);
    push_frame(-1, 1'b0, '0, '0);
    wait_drain(60);

    // Second done1 before done2 replaces the first U frame.
    rand_u();
    pulse(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rand_u();
    pulse(1'b1, 1'b0);
    rand_i();
    pulse(1'b0, 1'b1);
    push_frame(-1, 1'b0, '0, '0);
    wait_drain(60);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
